// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNTW  = 5;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // What the shared adder is doing this cycle.
    typedef enum logic [1:0] {
        M_MUL    = 2'd0,
        M_DIV    = 2'd1,
        M_NEG_LO = 2'd2,
        M_NEG_HI = 2'd3
    } step_mode_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply / restoring divide, or one negation pass, on a single adder.
// Purely combinational; no flow control.
module muldiv_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mplr,
    input  logic [WIDTH-1:0] mcand,
    input  logic             hi_cin,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] mplr_nxt,
    output logic [WIDTH-1:0] res,
    output logic             carry
);

    logic [WIDTH:0]   op_a;
    logic [WIDTH:0]   op_b;
    logic             cin;
    logic [WIDTH+1:0] sum;
    logic             ge;

    always_comb begin
        op_a = '0;
        op_b = '0;
        cin  = 1'b0;
        case (step_mode_t'(mode))
            M_MUL: begin
                op_a = {1'b0, acc};
                op_b = mplr[0] ? {1'b0, mcand} : '0;
            end
            M_DIV: begin
                op_a = {acc, mplr[WIDTH-1]};
                op_b = ~{1'b0, mcand};
                cin  = 1'b1;
            end
            M_NEG_LO: begin
                op_a = {1'b0, ~mplr};
                cin  = 1'b1;
            end
            M_NEG_HI: begin
                op_a = {1'b0, ~acc};
                cin  = hi_cin;
            end
            default: ;
        endcase
    end

    assign sum   = {1'b0, op_a} + {1'b0, op_b} + {{(WIDTH+1){1'b0}}, cin};
    // Carry out of the trial subtract means the shifted remainder >= divisor.
    assign ge    = sum[WIDTH+1];
    assign res   = sum[WIDTH-1:0];
    assign carry = sum[WIDTH];

    always_comb begin
        acc_nxt  = acc;
        mplr_nxt = mplr;
        if (step_mode_t'(mode) == M_DIV) begin
            acc_nxt  = ge ? sum[WIDTH-1:0] : op_a[WIDTH-1:0];
            mplr_nxt = {mplr[WIDTH-2:0], ge};
        end else if (step_mode_t'(mode) == M_MUL) begin
            acc_nxt  = sum[WIDTH:1];
            mplr_nxt = {sum[0], mplr[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO; WIDTH+2 cycles start-to-done (+1 when a
// signed result needs negating). No backpressure: caller stalls on busy; start is ignored while busy.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic             ph1,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             abort,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state, state_nxt;
    step_mode_t       mode;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] acc, mplr, mcand;
    logic             is_div, neg_lo, neg_hi, fix_pass, fix_carry;
    logic             need_neg, fix_last;
    logic             signed_op, div_op, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] acc_nxt, mplr_nxt, res;
    logic             carry;

    assign signed_op = (op == OP_MULT) || (op == OP_DIV);
    assign div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    assign a_neg     = signed_op & srca[WIDTH-1];
    assign b_neg     = signed_op & srcb[WIDTH-1];
    assign mag_a     = a_neg ? (~srca + 1'b1) : srca;
    assign mag_b     = b_neg ? (~srcb + 1'b1) : srcb;
    assign need_neg  = neg_lo | neg_hi;

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mode      = M_MUL;
        busy      = 1'b0;
        fix_last  = 1'b0;
        case (state)
            S_IDLE: if (start && !abort) state_nxt = S_CALC;
            S_CALC: begin
                busy = 1'b1;
                mode = is_div ? M_DIV : M_MUL;
                if (abort)                                state_nxt = S_IDLE;
                else if (cnt == CNTW'(WIDTH - 1))         state_nxt = S_FIX;
            end
            S_FIX: begin
                busy     = 1'b1;
                mode     = fix_pass ? M_NEG_HI : M_NEG_LO;
                fix_last = !abort && (!need_neg || fix_pass);
                if (abort || fix_last)                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (mode),
        .acc      (acc),
        .mplr     (mplr),
        .mcand    (mcand),
        .hi_cin   (is_div ? 1'b1 : fix_carry),
        .acc_nxt  (acc_nxt),
        .mplr_nxt (mplr_nxt),
        .res      (res),
        .carry    (carry)
    );

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            acc       <= '0;
            mplr      <= '0;
            mcand     <= '0;
            is_div    <= 1'b0;
            neg_lo    <= 1'b0;
            neg_hi    <= 1'b0;
            fix_pass  <= 1'b0;
            fix_carry <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (!abort) begin
                    if (start) begin
                        cnt      <= '0;
                        acc      <= '0;
                        fix_pass <= 1'b0;
                        is_div   <= div_op;
                        // Multiply: mcand=|a|, mplr=|b|. Divide: mplr holds the dividend.
                        mcand    <= div_op ? mag_b : mag_a;
                        mplr     <= div_op ? mag_a : mag_b;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= div_op ? a_neg : (a_neg ^ b_neg);
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                S_CALC: if (!abort) begin
                    acc  <= acc_nxt;
                    mplr <= mplr_nxt;
                    cnt  <= cnt + 1'b1;
                end
                S_FIX: if (!abort) begin
                    if (!fix_last) begin
                        if (neg_lo) mplr <= res;
                        fix_carry <= carry;
                        fix_pass  <= 1'b1;
                    end else begin
                        hi   <= (need_neg && neg_hi) ? res : acc;
                        lo   <= mplr;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latency, boundary divides, mthi/mtlo, abort, reset.
module tb_muldiv_seq;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        abort, mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int cyc;
    int pulses;

    muldiv_seq #(.WIDTH(32), .CNTW(5)) dut (
        .ph1   (ph1),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .abort (abort),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Start is sampled on the edge counted as cycle 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        @(posedge ph1);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int from, output int n);
        n = from;
        while (!done && n < 200) begin
            @(posedge ph1);
            #1 n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc);
        int n;
        launch(o, a, b);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(1, n);
        check({tag, "_cycles"}, 32'(n), 32'(ecyc));
        check({tag, "_hi"}, hi, ehi);
        check({tag, "_lo"}, lo, elo);
        @(posedge ph1);
        #1 check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
        abort = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(posedge ph1);
        #1 reset = 1'b1;

        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34);
        run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 35);
        run_op("div_m7d2",  2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 35);
        run_op("divu_d0",   2'b11, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 34);
        run_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 35);
        run_op("mult_min",  2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34);
        run_op("div_neg_d0",2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'h00000001, 35);
        run_op("divu_17d5", 2'b11, 32'd17,       32'd5,        32'h00000002, 32'h00000003, 34);

        // Register moves in IDLE.
        srca = 32'h12345678; mthi = 1'b1;
        @(posedge ph1);
        #1 mthi = 1'b0;
        check("mthi_hi", hi, 32'h12345678);
        check("mthi_lo_keep", lo, 32'h00000003);
        srca = 32'hCAFEBABE; mtlo = 1'b1;
        @(posedge ph1);
        #1 mtlo = 1'b0;
        check("mtlo_lo", lo, 32'hCAFEBABE);
        check("mtlo_hi_keep", hi, 32'h12345678);
        srca = 32'h0BADF00D; mthi = 1'b1; mtlo = 1'b1;
        @(posedge ph1);
        #1 begin mthi = 1'b0; mtlo = 1'b0; end
        check("mtboth_hi", hi, 32'h0BADF00D);
        check("mtboth_lo", lo, 32'h0BADF00D);

        // mthi alongside start, mthi while busy, and a stray start mid-op are all ignored.
        mthi = 1'b1;
        launch(2'b01, 32'd3, 32'd4);
        cyc = 1;
        check("mthi_start_hi", hi, 32'h0BADF00D);
        srca = 32'hDEADBEEF;
        repeat (4) begin
            @(posedge ph1);
            #1 cyc++;
        end
        check("mthi_busy_hi", hi, 32'h0BADF00D);
        mthi = 1'b0; op = 2'b11; srca = 32'd100; srcb = 32'd7; start = 1'b1;
        @(posedge ph1);
        #1 begin start = 1'b0; cyc++; end
        wait_done(cyc, cyc);
        check("midstart_cycles", 32'(cyc), 32'd34);
        check("midstart_hi", hi, 32'h0);
        check("midstart_lo", lo, 32'd12);

        // Abort at CALC cycle 10.
        launch(2'b11, 32'd9, 32'd2);
        repeat (10) @(posedge ph1);
        #1 abort = 1'b1;
        @(posedge ph1);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge ph1);
            #1 if (done) pulses++;
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'd12);

        // abort in IDLE suppresses a simultaneous start.
        op = 2'b01; srca = 32'd5; srcb = 32'd5; start = 1'b1; abort = 1'b1;
        @(posedge ph1);
        #1 begin start = 1'b0; abort = 1'b0; end
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset mid-CALC.
        launch(2'b01, 32'd5, 32'd6);
        repeat (4) @(posedge ph1);
        #1 reset = 1'b0;
        #2;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(posedge ph1);
        #1 reset = 1'b1;
        run_op("post_rst", 2'b01, 32'd3, 32'd4, 32'h0, 32'd12, 34);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
